// File: rtl/pwm_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// pwm_cfg_sequencer
//
// Configuration and restart sequencer for a bank of PWM channels. The host
// writes per-channel period (N), duty (D, 0.01 % units) and phase delay
// (degrees) into shadow registers. A commit copies every shadow register into
// the active registers in one cycle (APPLY). The shared PWM sclear is then held
// high for CLR_CYC more cycles (CLEAR) so that all channels reload and restart
// phase-aligned.
//
// Ports
//   clk, sclear                 clock, synchronous active-high reset
//   wr_valid / wr_ready         write handshake; transfer on valid & ready
//   wr_ch, wr_n, wr_d, wr_delay write target channel and requested values
//   commit                      single-cycle request to apply the shadows
//   enable                      level: 1 runs the bank, 0 parks it
//   pwm_n, pwm_d, pwm_delay     active values, channel i at [i*W +: W]
//   pwm_sclear                  shared restart to all PWM instances
//   running, busy               RUN state / APPLY or CLEAR state
//   cfg_valid                   at least one commit completed since reset
//   err, err_ch                 sticky invalid-write flag, first bad channel
// -----------------------------------------------------------------------------
module pwm_cfg_sequencer #(
  parameter int CH      = 4,
  parameter int W       = 26,
  parameter int CLR_CYC = 2,
  parameter int CW      = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            clk,
  input  logic            sclear,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [CW-1:0]   wr_ch,
  input  logic [W-1:0]    wr_n,
  input  logic [W-1:0]    wr_d,
  input  logic [W-1:0]    wr_delay,
  input  logic            commit,
  input  logic            enable,
  output logic [CH*W-1:0] pwm_n,
  output logic [CH*W-1:0] pwm_d,
  output logic [CH*W-1:0] pwm_delay,
  output logic            pwm_sclear,
  output logic            running,
  output logic            busy,
  output logic            cfg_valid,
  output logic            err,
  output logic [CW-1:0]   err_ch
);

  // The CLEAR counter must hold CLR_CYC-1.
  localparam int              CNTW     = (CLR_CYC > 2) ? $clog2(CLR_CYC) : 1;
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(CLR_CYC - 1);

  localparam logic [W-1:0] D_MAX     = W'(10000);
  localparam logic [W-1:0] DELAY_MAX = W'(359);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_APPLY,
    S_CLEAR
  } state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            pending_q, pending_d;
  logic            cfg_valid_q, cfg_valid_d;
  logic            err_q, err_d;
  logic [CW-1:0]   err_ch_q, err_ch_d;
  logic            pwm_sclear_q;
  logic            running_q;
  logic            busy_q;

  logic [W-1:0] shadow_n_q     [CH];
  logic [W-1:0] shadow_d_q     [CH];
  logic [W-1:0] shadow_delay_q [CH];
  logic [W-1:0] active_n_q     [CH];
  logic [W-1:0] active_d_q     [CH];
  logic [W-1:0] active_delay_q [CH];

  logic wr_fire;
  logic wr_ok;
  logic ch_ok;

  // Writes are accepted only in the steady states, so the shadow registers
  // never change in the same cycle they are copied in APPLY.
  assign wr_ready = ((state_q == S_IDLE) || (state_q == S_RUN)) && !sclear;
  assign wr_fire  = wr_valid && wr_ready;

  // Zero-extend both sides so the range check also works when CH is a
  // power of two and every wr_ch encoding is legal.
  assign ch_ok = (32'(wr_ch) < 32'(CH));
  assign wr_ok = (wr_n != '0) && (wr_d <= D_MAX) && (wr_delay <= DELAY_MAX) && ch_ok;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is
    // inferred on paths that do not assign it.
    state_d     = state_q;
    cnt_d       = cnt_q;
    pending_d   = pending_q;
    cfg_valid_d = cfg_valid_q;
    err_d       = err_q;
    err_ch_d    = err_ch_q;

    unique case (state_q)
      S_IDLE: begin
        if (commit) begin
          state_d = S_APPLY;
        end else if (enable && cfg_valid_q) begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        // A commit wins over enable falling in the same cycle.
        if (commit) begin
          state_d = S_APPLY;
        end else if (!enable) begin
          state_d = S_IDLE;
        end
      end

      S_APPLY: begin
        state_d     = S_CLEAR;
        cnt_d       = CNT_LOAD;
        cfg_valid_d = 1'b1;
        if (commit) begin
          pending_d = 1'b1;
        end
      end

      S_CLEAR: begin
        if (cnt_q == '0) begin
          // A commit arriving on the last CLEAR cycle is treated like a
          // pending one rather than being dropped.
          if (pending_q || commit) begin
            state_d   = S_APPLY;
            pending_d = 1'b0;
          end else if (enable) begin
            state_d = S_RUN;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (commit) begin
            pending_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Rejected writes are still consumed; only the first bad channel is kept.
    if (wr_fire && !wr_ok) begin
      err_d = 1'b1;
      if (!err_q) begin
        err_ch_d = wr_ch;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM and status registers. Outputs are decoded from state_d so they are
  // registered and line up with the state they describe.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    if (sclear) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      cfg_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      err_ch_q     <= '0;
      pwm_sclear_q <= 1'b1;
      running_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      cfg_valid_q  <= cfg_valid_d;
      err_q        <= err_d;
      err_ch_q     <= err_ch_d;
      pwm_sclear_q <= (state_d != S_RUN);
      running_q    <= (state_d == S_RUN);
      busy_q       <= (state_d == S_APPLY) || (state_d == S_CLEAR);
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow and active parameter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (sclear) begin
      // NOTE: these register arrays are reset on purpose: the PWM bank must see
      // all-zero parameters out of reset, so they cannot map to a RAM.
      for (int i = 0; i < CH; i++) begin
        shadow_n_q[i]     <= '0;
        shadow_d_q[i]     <= '0;
        shadow_delay_q[i] <= '0;
        active_n_q[i]     <= '0;
        active_d_q[i]     <= '0;
        active_delay_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (wr_fire && wr_ok && (wr_ch == CW'(i))) begin
          shadow_n_q[i]     <= wr_n;
          shadow_d_q[i]     <= wr_d;
          shadow_delay_q[i] <= wr_delay;
        end
        // Active values only move while sclear is held high.
        if (state_q == S_APPLY) begin
          active_n_q[i]     <= shadow_n_q[i];
          active_d_q[i]     <= shadow_d_q[i];
          active_delay_q[i] <= shadow_delay_q[i];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output packing
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < CH; g++) begin : g_pack
    assign pwm_n[g*W +: W]     = active_n_q[g];
    assign pwm_d[g*W +: W]     = active_d_q[g];
    assign pwm_delay[g*W +: W] = active_delay_q[g];
  end

  assign pwm_sclear = pwm_sclear_q;
  assign running    = running_q;
  assign busy       = busy_q;
  assign cfg_valid  = cfg_valid_q;
  assign err        = err_q;
  assign err_ch     = err_ch_q;

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pwm_cfg_sequencer
//
// Directed bench for pwm_cfg_sequencer with CH=4, W=26, CLR_CYC=2. Inputs are
// driven 1 time unit after each rising edge and outputs are checked at the same
// point, so "cycle j" below is the interval that follows edge j-1.
// -----------------------------------------------------------------------------
module tb_pwm_cfg_sequencer;

  localparam int CH      = 4;
  localparam int W       = 26;
  localparam int CLR_CYC = 2;
  localparam int CW      = 2;

  // Expected active vectors, channel 3 in the MSBs.
  localparam logic [CH*W-1:0] ZERO  = '0;
  localparam logic [CH*W-1:0] N_A   = {26'd0, 26'd0, 26'd198,  26'd198};
  localparam logic [CH*W-1:0] D_A   = {26'd0, 26'd0, 26'd2500, 26'd5000};
  localparam logic [CH*W-1:0] DL_A  = {26'd0, 26'd0, 26'd180,  26'd90};
  localparam logic [CH*W-1:0] D_B   = {26'd0, 26'd0, 26'd2500, 26'd7500};

  logic            clk = 1'b0;
  logic            sclear;
  logic            wr_valid;
  logic            wr_ready;
  logic [CW-1:0]   wr_ch;
  logic [W-1:0]    wr_n;
  logic [W-1:0]    wr_d;
  logic [W-1:0]    wr_delay;
  logic            commit;
  logic            enable;
  logic [CH*W-1:0] pwm_n;
  logic [CH*W-1:0] pwm_d;
  logic [CH*W-1:0] pwm_delay;
  logic            pwm_sclear;
  logic            running;
  logic            busy;
  logic            cfg_valid;
  logic            err;
  logic [CW-1:0]   err_ch;

  int checks = 0;
  int errors = 0;

  pwm_cfg_sequencer #(
    .CH      (CH),
    .W       (W),
    .CLR_CYC (CLR_CYC)
  ) dut (
    .clk        (clk),
    .sclear     (sclear),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_ch      (wr_ch),
    .wr_n       (wr_n),
    .wr_d       (wr_d),
    .wr_delay   (wr_delay),
    .commit     (commit),
    .enable     (enable),
    .pwm_n      (pwm_n),
    .pwm_d      (pwm_d),
    .pwm_delay  (pwm_delay),
    .pwm_sclear (pwm_sclear),
    .running    (running),
    .busy       (busy),
    .cfg_valid  (cfg_valid),
    .err        (err),
    .err_ch     (err_ch)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_write(input int ch, input int n, input int d, input int dl);
    wr_valid = 1'b1;
    wr_ch    = CW'(ch);
    wr_n     = W'(n);
    wr_d     = W'(d);
    wr_delay = W'(dl);
  endtask

  task automatic do_write(input int ch, input int n, input int d, input int dl);
    set_write(ch, n, d, dl);
    tick();
    wr_valid = 1'b0;
  endtask

  // Safety net in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog expired before the summary line");
    $fatal(1, "watchdog");
  end

  initial begin
    sclear   = 1'b1;
    wr_valid = 1'b0;
    wr_ch    = '0;
    wr_n     = '0;
    wr_d     = '0;
    wr_delay = '0;
    commit   = 1'b0;
    enable   = 1'b1;

    // ---------------- Reset and idle ----------------
    tick();
    tick();
    tick();
    check("rst_wr_ready", wr_ready, 1'b0);
    check("rst_pwm_sclear", pwm_sclear, 1'b1);
    sclear = 1'b0;
    #1;
    check("rel_wr_ready", wr_ready, 1'b1);
    tick();
    check("idle_pwm_sclear", pwm_sclear, 1'b1);
    check("idle_pwm_n", pwm_n, ZERO);
    check("idle_pwm_d", pwm_d, ZERO);
    check("idle_running", running, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("idle_cfg_valid", cfg_valid, 1'b0);
    check("idle_err", err, 1'b0);

    // ---------------- Basic commit ----------------
    do_write(0, 198, 5000, 90);
    set_write(1, 198, 2500, 180);   // write in the same cycle as commit
    commit = 1'b1;
    tick();                          // edge k sampled -> cycle k+1
    wr_valid = 1'b0;
    commit   = 1'b0;
    check("apply_busy", busy, 1'b1);
    check("apply_wr_ready", wr_ready, 1'b0);
    check("apply_pwm_sclear", pwm_sclear, 1'b1);
    check("apply_pwm_n_old", pwm_n, ZERO);
    tick();                          // cycle k+2
    check("clr1_pwm_n", pwm_n, N_A);
    check("clr1_pwm_d", pwm_d, D_A);
    check("clr1_pwm_delay", pwm_delay, DL_A);
    check("clr1_cfg_valid", cfg_valid, 1'b1);
    check("clr1_pwm_sclear", pwm_sclear, 1'b1);
    tick();                          // cycle k+3
    check("clr2_pwm_sclear", pwm_sclear, 1'b1);
    check("clr2_running", running, 1'b0);
    tick();                          // cycle k+4
    check("run_running", running, 1'b1);
    check("run_pwm_sclear", pwm_sclear, 1'b0);
    check("run_busy", busy, 1'b0);

    // ---------------- Invalid writes ----------------
    check("inv_wr_ready", wr_ready, 1'b1);
    do_write(2, 198, 10001, 0);
    check("inv1_err", err, 1'b1);
    check("inv1_err_ch", err_ch, 2'd2);
    do_write(3, 198, 0, 360);
    check("inv2_err", err, 1'b1);
    check("inv2_err_ch", err_ch, 2'd2);
    check("inv_running", running, 1'b1);

    // ---------------- Commit during CLEAR ----------------
    commit = 1'b1;
    tick();                          // cycle k+1: APPLY
    commit = 1'b0;
    check("c2_apply_busy", busy, 1'b1);
    tick();                          // cycle k+2: CLEAR, second commit here
    commit = 1'b1;
    set_write(0, 198, 7500, 90);
    #1;
    check("c2_clr_wr_ready", wr_ready, 1'b0);
    tick();                          // cycle k+3
    commit = 1'b0;
    check("c2_stall_wr_ready", wr_ready, 1'b0);
    check("c2_k3_pwm_sclear", pwm_sclear, 1'b1);
    tick();                          // cycle k+4: APPLY again
    check("c2_reapply_busy", busy, 1'b1);
    check("c2_reapply_wr_ready", wr_ready, 1'b0);
    check("c2_reapply_pwm_d", pwm_d, D_A);
    tick();                          // cycle k+5
    check("c2_k5_pwm_n", pwm_n, N_A);
    check("c2_k5_pwm_d", pwm_d, D_A);
    check("c2_k5_pwm_delay", pwm_delay, DL_A);
    tick();                          // cycle k+6
    check("c2_k6_pwm_sclear", pwm_sclear, 1'b1);
    check("c2_k6_running", running, 1'b0);
    tick();                          // cycle k+7: RUN, stalled write goes now
    check("c2_k7_running", running, 1'b1);
    check("c2_k7_wr_ready", wr_ready, 1'b1);
    tick();
    wr_valid = 1'b0;
    check("c2_after_wr_pwm_d", pwm_d, D_A);
    check("c2_after_wr_running", running, 1'b1);

    // ---------------- Commit and enable low together ----------------
    commit = 1'b1;
    enable = 1'b0;
    tick();                          // APPLY
    commit = 1'b0;
    check("sim_apply_busy", busy, 1'b1);
    check("sim_apply_pwm_sclear", pwm_sclear, 1'b1);
    tick();                          // CLEAR
    check("sim_clr1_pwm_d", pwm_d, D_B);
    check("sim_clr1_pwm_sclear", pwm_sclear, 1'b1);
    tick();                          // CLEAR
    check("sim_clr2_pwm_sclear", pwm_sclear, 1'b1);
    tick();                          // IDLE
    check("sim_idle_busy", busy, 1'b0);
    check("sim_idle_running", running, 1'b0);
    check("sim_idle_pwm_sclear", pwm_sclear, 1'b1);
    tick();
    check("sim_idle2_running", running, 1'b0);

    // ---------------- Enable rising in IDLE ----------------
    enable = 1'b1;
    tick();
    check("en_running", running, 1'b1);
    check("en_pwm_sclear", pwm_sclear, 1'b0);

    // ---------------- Reset mid-CLEAR ----------------
    commit = 1'b1;
    tick();                          // APPLY; keep commit to set pending
    check("rc_apply_busy", busy, 1'b1);
    tick();                          // CLEAR (k+2)
    commit = 1'b0;
    sclear = 1'b1;
    tick();
    check("rc_busy", busy, 1'b0);
    check("rc_running", running, 1'b0);
    check("rc_pwm_n", pwm_n, ZERO);
    check("rc_pwm_d", pwm_d, ZERO);
    check("rc_pwm_delay", pwm_delay, ZERO);
    check("rc_cfg_valid", cfg_valid, 1'b0);
    check("rc_err", err, 1'b0);
    check("rc_pwm_sclear", pwm_sclear, 1'b1);
    check("rc_wr_ready", wr_ready, 1'b0);
    sclear = 1'b0;
    tick();
    check("rc_idle_running", running, 1'b0);
    check("rc_idle_busy", busy, 1'b0);

    // A fresh commit must run exactly one APPLY/CLEAR pass: a stale pending
    // flag would cause a second APPLY instead of RUN.
    commit = 1'b1;
    tick();                          // APPLY
    commit = 1'b0;
    tick();                          // CLEAR
    check("rc2_pwm_d", pwm_d, ZERO);
    tick();                          // CLEAR
    tick();                          // RUN expected
    check("rc2_running", running, 1'b1);
    check("rc2_busy", busy, 1'b0);
    check("rc2_cfg_valid", cfg_valid, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
